// File: rtl/irq_timer_if.sv
// Data-memory bus bundle between the CPU (master) and the irq_timer peripheral (slave).
interface irq_timer_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Hit;

  modport master (
    output MemRead, MemWrite, Address, WriteData,
    input  ReadData, Hit
  );

  modport slave (
    input  MemRead, MemWrite, Address, WriteData,
    output ReadData, Hit
  );
endinterface

// File: rtl/irq_timer.sv
// Memory-mapped 32-bit reload timer that raises a level IRQ on overflow.
// Define IRQ_TIMER_SYSTICK_EN to add a free-running SYSTICK counter at offset 0x0C.
module irq_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h40000000
) (
  input  logic          clk,
  input  logic          reset,
  irq_timer_if.slave    bus,
  output logic          IRQ
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic        en_q, en_d;
  logic        ie_q, ie_d;
  logic        st_q, st_d;

  logic        hit;
  logic [2:0]  offset;
  logic        wr_th, wr_tl, wr_tcon;
  logic        tl_at_max;
  logic        overflow;
  logic [1:0]  unused_addr_bits;

  assign hit              = (bus.Address[31:5] == BASE_ADDR[31:5]);
  assign offset           = bus.Address[4:2];
  assign unused_addr_bits = bus.Address[1:0];
  assign bus.Hit          = hit;

  assign wr_th   = bus.MemWrite && hit && (offset == 3'd0);
  assign wr_tl   = bus.MemWrite && hit && (offset == 3'd1);
  assign wr_tcon = bus.MemWrite && hit && (offset == 3'd2);

  assign tl_at_max = (tl_q == 32'hFFFF_FFFF);
  // A software write to TL suppresses both the increment and the overflow it would cause.
  assign overflow  = en_q && tl_at_max && !wr_tl;

  assign IRQ = ie_q && st_q;

`ifdef IRQ_TIMER_SYSTICK_EN
  logic [31:0] systick_q, systick_d;

  assign systick_d = systick_q + 32'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      systick_q <= 32'd0;
    end else begin
      systick_q <= systick_d;
    end
  end
`endif

  always_comb begin
    bus.ReadData = 32'd0;
    if (bus.MemRead && hit) begin
      case (offset)
        3'd0:    bus.ReadData = th_q;
        3'd1:    bus.ReadData = tl_q;
        3'd2:    bus.ReadData = {29'd0, st_q, ie_q, en_q};
`ifdef IRQ_TIMER_SYSTICK_EN
        3'd3:    bus.ReadData = systick_q;
`endif
        default: bus.ReadData = 32'd0;
      endcase
    end
  end

  always_comb begin
    th_d = th_q;
    tl_d = tl_q;
    en_d = en_q;
    ie_d = ie_q;
    st_d = st_q;

    if (wr_th) begin
      th_d = bus.WriteData;
    end

    if (wr_tl) begin
      tl_d = bus.WriteData;
    end else if (en_q) begin
      tl_d = tl_at_max ? th_q : (tl_q + 32'd1);
    end

    if (wr_tcon) begin
      en_d = bus.WriteData[0];
      ie_d = bus.WriteData[1];
      if (!bus.WriteData[2]) begin
        st_d = 1'b0;
      end
    end

    // Setting after the clear lets an overflow win over a same-cycle ST clear.
    if (overflow && ie_q) begin
      st_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q <= 32'd0;
      tl_q <= 32'd0;
      en_q <= 1'b0;
      ie_q <= 1'b0;
      st_q <= 1'b0;
    end else begin
      th_q <= th_d;
      tl_q <= tl_d;
      en_q <= en_d;
      ie_q <= ie_d;
      st_q <= st_d;
    end
  end

endmodule
